// File: rtl/cdf_builder.sv
// ============================================================================
// cdf_builder
// ----------------------------------------------------------------------------
// Purpose:
//   Walks the 256-bin luminance histogram of a finished frame and builds the
//   cumulative distribution function (CDF) used by the output mapper. The
//   block also finds the first non-zero CDF value (cdf_min) and flags frames
//   whose pixel total is wrong or whose CDF would give a zero divisor
//   downstream. Each histogram bin is zeroed as it is consumed, so the
//   histogram bank is clean for the next frame that uses it.
//
//   Scan timeline, with `start` accepted at edge t:
//     t+1   .. t+256  histogram reads, addresses 0..255
//     t+2+k           read data for bin k is returned
//     t+3+k           CDF write and histogram clear for bin k
//     t+259           cdf_valid pulse; cdf_min and flags already updated
//     t+260           idle again; a new start can be accepted here
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset          in   synchronous, active-high reset
//   start          in   one-cycle pulse that begins a scan (honoured in IDLE)
//   bank           in   histogram/CDF bank select, sampled with start
//   hist_rd_en     out  histogram read strobe
//   hist_rd_addr   out  histogram read address
//   hist_rd_data   in   histogram count, one cycle after hist_rd_en
//   hist_clr_en    out  write zero to hist_clr_addr
//   hist_clr_addr  out  bin being cleared
//   cdf_wr_en      out  CDF RAM write strobe
//   cdf_wr_addr    out  CDF RAM write address
//   cdf_wr_data    out  cumulative count written
//   cdf_bank       out  bank latched at start, applies to all RAM ports
//   cdf_min        out  first non-zero CDF value of the last scan
//   cdf_valid      out  one-cycle pulse, scan complete
//   busy           out  scan in progress
//   total_error    out  final sum differs from PIXELS or accumulator saturated
//   flat_image     out  cdf_min equals PIXELS (zero divisor downstream)
// ============================================================================
module cdf_builder #(
    parameter int BINS    = 256,
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 20,
    parameter int PIXELS  = 307200
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               bank,
    output logic               hist_rd_en,
    output logic [ADDR_W-1:0]  hist_rd_addr,
    input  logic [COUNT_W-1:0] hist_rd_data,
    output logic               hist_clr_en,
    output logic [ADDR_W-1:0]  hist_clr_addr,
    output logic               cdf_wr_en,
    output logic [ADDR_W-1:0]  cdf_wr_addr,
    output logic [COUNT_W-1:0] cdf_wr_data,
    output logic               cdf_bank,
    output logic [COUNT_W-1:0] cdf_min,
    output logic               cdf_valid,
    output logic               busy,
    output logic               total_error,
    output logic               flat_image
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(BINS - 1);
    localparam logic [COUNT_W-1:0] SAT_VAL   = '1;
    localparam logic [COUNT_W-1:0] PIXELS_C  = COUNT_W'(PIXELS);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_busy;
    logic   w_valid;

    // Read address generator
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_bank;

    // DRAIN lasts two cycles: one for the last read data, one for its write
    logic               r_drain_cnt;

    // Read-data stage: marks the cycle in which hist_rd_data is valid
    logic               r_dat_vld;
    logic [ADDR_W-1:0]  r_dat_addr;

    // Write/clear stage
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [COUNT_W-1:0] r_wr_data;

    // Accumulation and minimum search
    logic [COUNT_W-1:0] r_acc;
    logic               r_sat;
    logic [COUNT_W-1:0] r_min;
    logic               r_min_found;

    // Results held for the frame controller
    logic [COUNT_W-1:0] r_cdf_min;
    logic               r_total_error;
    logic               r_flat_image;

    logic               w_start_acc;
    logic               w_finish;
    logic [COUNT_W:0]   w_sum;
    logic               w_carry;
    logic [COUNT_W-1:0] w_acc_next;

    assign w_start_acc = (r_state == S_IDLE) && start;

    // Last DRAIN cycle: the final bin has been accumulated into r_acc
    assign w_finish    = (r_state == S_DRAIN) && r_drain_cnt;

    // One extra bit catches the carry out of the accumulator
    assign w_sum       = {1'b0, r_acc} + {1'b0, hist_rd_data};
    assign w_carry     = w_sum[COUNT_W];
    assign w_acc_next  = w_carry ? SAT_VAL : w_sum[COUNT_W-1:0];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_valid      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                if (r_rd_addr == LAST_ADDR) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_valid      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of the others.
            r_rd_en       <= 1'b0;
            r_rd_addr     <= '0;
            r_bank        <= 1'b0;
            r_drain_cnt   <= 1'b0;
            r_dat_vld     <= 1'b0;
            r_dat_addr    <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_acc         <= '0;
            r_sat         <= 1'b0;
            r_min         <= '0;
            r_min_found   <= 1'b0;
            r_cdf_min     <= '0;
            r_total_error <= 1'b0;
            r_flat_image  <= 1'b0;
        end else begin
            // Address generator: 0..255, one per cycle while in READ
            if (w_start_acc) begin
                r_rd_en   <= 1'b1;
                r_rd_addr <= '0;
                r_bank    <= bank;
            end else if (r_state == S_READ) begin
                if (r_rd_addr == LAST_ADDR) begin
                    r_rd_en <= 1'b0;
                end else begin
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                end
            end

            r_drain_cnt <= (r_state == S_DRAIN) && !r_drain_cnt;

            // Read data comes back one cycle after the strobe
            r_dat_vld  <= r_rd_en;
            r_dat_addr <= r_rd_addr;

            // The write and the clear of a bin share one register stage, so
            // the clear always trails its read by two cycles and can never
            // collide with a read of the same bin.
            r_wr_en <= r_dat_vld;
            if (r_dat_vld) begin
                r_wr_addr <= r_dat_addr;
                r_wr_data <= w_acc_next;
            end

            // Accumulator, saturation and minimum search
            if (w_start_acc) begin
                r_acc       <= '0;
                r_sat       <= 1'b0;
                r_min       <= '0;
                r_min_found <= 1'b0;
            end else if (r_dat_vld) begin
                r_acc <= w_acc_next;
                if (w_carry) begin
                    r_sat <= 1'b1;
                end
                if (!r_min_found && (w_acc_next != '0)) begin
                    r_min       <= w_acc_next;
                    r_min_found <= 1'b1;
                end
            end

            // Results are published one cycle before cdf_valid is seen, so
            // they are stable for the whole valid pulse and held afterwards.
            if (w_finish) begin
                r_cdf_min     <= r_min;
                r_total_error <= r_sat | (r_acc != PIXELS_C);
                r_flat_image  <= (r_min == PIXELS_C);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign hist_rd_en    = r_rd_en;
    assign hist_rd_addr  = r_rd_addr;
    assign hist_clr_en   = r_wr_en;
    assign hist_clr_addr = r_wr_addr;
    assign cdf_wr_en     = r_wr_en;
    assign cdf_wr_addr   = r_wr_addr;
    assign cdf_wr_data   = r_wr_data;
    assign cdf_bank      = r_bank;
    assign cdf_min       = r_cdf_min;
    assign cdf_valid     = w_valid;
    assign busy          = w_busy;
    assign total_error   = r_total_error;
    assign flat_image    = r_flat_image;

endmodule

// File: tb/tb_cdf_builder.sv
// ============================================================================
// tb_cdf_builder
// ----------------------------------------------------------------------------
// Self-checking bench for cdf_builder. A behavioural histogram RAM (two
// banks, synchronous read, clear port) feeds the DUT; a negedge monitor logs
// every CDF write and every cdf_valid pulse with the edge at which it is
// seen. Expected CDF values, minimum and flags come from a plain running-sum
// model of each frame's histogram.
// ============================================================================
module tb_cdf_builder;

    localparam int     BINS    = 256;
    localparam int     ADDR_W  = 8;
    localparam int     COUNT_W = 20;
    localparam int     PIXELS  = 307200;
    localparam longint SAT     = (64'd1 << COUNT_W) - 1;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               bank  = 1'b0;
    logic               hist_rd_en;
    logic [ADDR_W-1:0]  hist_rd_addr;
    logic [COUNT_W-1:0] hist_rd_data = '0;
    logic               hist_clr_en;
    logic [ADDR_W-1:0]  hist_clr_addr;
    logic               cdf_wr_en;
    logic [ADDR_W-1:0]  cdf_wr_addr;
    logic [COUNT_W-1:0] cdf_wr_data;
    logic               cdf_bank;
    logic [COUNT_W-1:0] cdf_min;
    logic               cdf_valid;
    logic               busy;
    logic               total_error;
    logic               flat_image;

    cdf_builder #(
        .BINS    (BINS),
        .ADDR_W  (ADDR_W),
        .COUNT_W (COUNT_W),
        .PIXELS  (PIXELS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .bank          (bank),
        .hist_rd_en    (hist_rd_en),
        .hist_rd_addr  (hist_rd_addr),
        .hist_rd_data  (hist_rd_data),
        .hist_clr_en   (hist_clr_en),
        .hist_clr_addr (hist_clr_addr),
        .cdf_wr_en     (cdf_wr_en),
        .cdf_wr_addr   (cdf_wr_addr),
        .cdf_wr_data   (cdf_wr_data),
        .cdf_bank      (cdf_bank),
        .cdf_min       (cdf_min),
        .cdf_valid     (cdf_valid),
        .busy          (busy),
        .total_error   (total_error),
        .flat_image    (flat_image)
    );

    always #5 clock = ~clock;

    // Edge counter: after rising edge n, cyc == n
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Histogram RAM model: synchronous read, clear port
    // ------------------------------------------------------------------------
    logic [COUNT_W-1:0] hist_mem [2][BINS];

    always @(posedge clock) begin
        if (hist_rd_en) hist_rd_data <= hist_mem[cdf_bank][hist_rd_addr];
        if (hist_clr_en) hist_mem[cdf_bank][hist_clr_addr] = '0;
    end

    // ------------------------------------------------------------------------
    // Monitor: values seen at negedge after edge n belong to edge n+1
    // ------------------------------------------------------------------------
    typedef struct {
        int cyc;
        int addr;
        int data;
        bit bnk;
    } wr_t;

    wr_t                wr_q[$];
    int                 val_q[$];
    wr_t                mon_w;
    int                 clr_bad = 0;
    logic [COUNT_W-1:0] val_min;
    logic               val_err;
    logic               val_flat;

    always @(negedge clock) begin
        if (cdf_wr_en) begin
            mon_w.cyc  = cyc + 1;
            mon_w.addr = int'(cdf_wr_addr);
            mon_w.data = int'(cdf_wr_data);
            mon_w.bnk  = cdf_bank;
            wr_q.push_back(mon_w);
        end
        if ((hist_clr_en !== cdf_wr_en) || (hist_clr_en && (hist_clr_addr !== cdf_wr_addr)))
            clr_bad++;
        if (cdf_valid) begin
            val_q.push_back(cyc + 1);
            val_min  = cdf_min;
            val_err  = total_error;
            val_flat = flat_image;
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Frame stimulus and reference results
    int unsigned hist_in [BINS];
    longint      exp_cdf [BINS];
    longint      exp_min;
    bit          exp_err;
    bit          exp_flat;

    task automatic fill(input int unsigned v);
        for (int k = 0; k < BINS; k++) hist_in[k] = v;
    endtask

    // Runs one frame starting at the current negedge. Returns at the negedge
    // where edge t+260 is seen, so a following call starts exactly at t+260.
    // With poke set, bank is toggled and start pulsed so start lands at t+50.
    task automatic run_frame(input string name, input bit bsel, input bit poke);
        int     t;
        int     busy_bad = 0;
        int     rd_bad   = 0;
        int     bank_bad = 0;
        int     wr_bad   = 0;
        int     nz       = 0;
        longint acc      = 0;
        bit     sat      = 0;
        bit     found    = 0;

        // Reference model: running sum with saturation, first non-zero value
        exp_min = 0;
        for (int k = 0; k < BINS; k++) begin
            hist_mem[bsel][k] = COUNT_W'(hist_in[k]);
            acc += longint'(hist_in[k]);
            if (acc > SAT) begin
                acc = SAT;
                sat = 1'b1;
            end
            exp_cdf[k] = acc;
            if (!found && acc != 0) begin
                exp_min = acc;
                found   = 1'b1;
            end
        end
        exp_err  = sat || (acc != PIXELS);
        exp_flat = (exp_min == PIXELS);

        wr_q.delete();
        val_q.delete();
        clr_bad  = 0;
        val_min  = 'x;
        val_err  = 1'bx;
        val_flat = 1'bx;

        bank  = bsel;
        start = 1'b1;
        t     = cyc + 1;
        @(negedge clock);
        start = 1'b0;

        for (int v = t + 1; v <= t + 260; v++) begin
            if (v > t + 1) @(negedge clock);
            if (poke && v == t + 50) begin
                start = 1'b1;
                bank  = ~bsel;
            end
            if (poke && v == t + 51) start = 1'b0;
            if (busy !== (v <= t + 259)) busy_bad++;
            if (hist_rd_en !== (v <= t + 256)) rd_bad++;
            else if (hist_rd_en && (hist_rd_addr !== ADDR_W'(v - t - 1))) rd_bad++;
            if (cdf_bank !== bsel) bank_bad++;
        end
        bank = bsel;

        foreach (wr_q[i]) begin
            if (i >= BINS) wr_bad++;
            else if ((wr_q[i].cyc != t + 3 + i) || (wr_q[i].addr != i) ||
                     (longint'(wr_q[i].data) != exp_cdf[i]) || (wr_q[i].bnk != bsel))
                wr_bad++;
        end
        for (int k = 0; k < BINS; k++)
            if (hist_mem[bsel][k] != '0) nz++;

        check($sformatf("%s/busy_window", name), 32'(busy_bad), 32'd0);
        check($sformatf("%s/read_sequence", name), 32'(rd_bad), 32'd0);
        check($sformatf("%s/cdf_bank", name), 32'(bank_bad), 32'd0);
        check($sformatf("%s/valid_count", name), 32'(val_q.size()), 32'd1);
        check($sformatf("%s/valid_time", name),
              32'((val_q.size() > 0) ? val_q[0] - t : -1), 32'd259);
        check($sformatf("%s/cdf_min", name), 32'(val_min), 32'(exp_min));
        check($sformatf("%s/total_error", name), 32'(val_err), 32'(exp_err));
        check($sformatf("%s/flat_image", name), 32'(val_flat), 32'(exp_flat));
        check($sformatf("%s/cdf_min_held", name), 32'(cdf_min), 32'(exp_min));
        check($sformatf("%s/write_count", name), 32'(wr_q.size()), 32'(BINS));
        check($sformatf("%s/write_content", name), 32'(wr_bad), 32'd0);
        check($sformatf("%s/clear_vs_write", name), 32'(clr_bad), 32'd0);
        check($sformatf("%s/hist_cleared", name), 32'(nz), 32'd0);
    endtask

    // Reset asserted so that it is sampled at edge t+100 of a running scan
    task automatic reset_scan();
        int t;
        for (int k = 0; k < BINS; k++) hist_mem[0][k] = COUNT_W'(1200);
        val_q.delete();
        bank  = 1'b0;
        start = 1'b1;
        t     = cyc + 1;
        @(negedge clock);
        start = 1'b0;
        while (cyc + 1 < t + 100) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_reset/busy", 32'(busy), 32'd0);
        check("mid_reset/hist_rd_en", 32'(hist_rd_en), 32'd0);
        check("mid_reset/cdf_wr_en", 32'(cdf_wr_en), 32'd0);
        check("mid_reset/hist_clr_en", 32'(hist_clr_en), 32'd0);
        check("mid_reset/cdf_min", 32'(cdf_min), 32'd0);
        repeat (300) @(negedge clock);
        check("mid_reset/no_valid", 32'(val_q.size()), 32'd0);
    endtask

    // Watchdog: every wait is a fixed count, this only trips on a hang
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int unsigned remaining;
        int unsigned v;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/cdf_valid", 32'(cdf_valid), 32'd0);
        check("reset/hist_rd_en", 32'(hist_rd_en), 32'd0);
        check("reset/hist_clr_en", 32'(hist_clr_en), 32'd0);
        check("reset/cdf_wr_en", 32'(cdf_wr_en), 32'd0);
        check("reset/cdf_wr_data", 32'(cdf_wr_data), 32'd0);
        check("reset/cdf_min", 32'(cdf_min), 32'd0);
        check("reset/total_error", 32'(total_error), 32'd0);
        check("reset/flat_image", 32'(flat_image), 32'd0);
        check("reset/cdf_bank", 32'(cdf_bank), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle/busy", 32'(busy), 32'd0);

        // Uniform histogram: CDF 1200*(k+1), min 1200, clean flags
        fill(1200);
        run_frame("uniform", 1'b0, 1'b0);
        repeat (2) @(negedge clock);

        // Flat image: everything in bin 100
        fill(0);
        hist_in[100] = PIXELS;
        run_frame("flat", 1'b1, 1'b0);
        repeat (2) @(negedge clock);

        // Leading zeros
        fill(0);
        hist_in[10]  = 5;
        hist_in[255] = PIXELS - 5;
        run_frame("leading_zeros", 1'b0, 1'b0);
        repeat (2) @(negedge clock);

        // Wrong total
        fill(1);
        run_frame("all_ones", 1'b0, 1'b0);
        repeat (2) @(negedge clock);

        // Saturation
        fill(32'hFFFFF);
        run_frame("saturate", 1'b1, 1'b0);
        repeat (2) @(negedge clock);

        // Ignored start and bank change mid-scan, then a start at t+260
        fill(1200);
        run_frame("bank_busy", 1'b1, 1'b1);
        fill(2400);
        hist_in[0] = 0;
        run_frame("back_to_back", 1'b1, 1'b0);
        repeat (2) @(negedge clock);

        // Random histograms summing exactly to PIXELS
        for (int r = 0; r < 3; r++) begin
            remaining = PIXELS;
            for (int k = 0; k < BINS - 1; k++) begin
                v = (remaining < 2400) ? remaining : 2400;
                hist_in[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, v);
                remaining -= hist_in[k];
            end
            hist_in[BINS-1] = remaining;
            run_frame($sformatf("rand_exact%0d", r), r[0], 1'b0);
            repeat (2) @(negedge clock);
        end

        // Random histograms with arbitrary totals
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < BINS; k++)
                hist_in[k] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4000);
            run_frame($sformatf("rand_any%0d", r), ~r[0], 1'b0);
            repeat (2) @(negedge clock);
        end

        // Reset in the middle of a scan, then a normal frame
        reset_scan();
        fill(1200);
        run_frame("after_reset", 1'b0, 1'b0);
        repeat (2) @(negedge clock);

        // Empty histogram: min 0, total wrong
        fill(0);
        run_frame("empty", 1'b0, 1'b0);
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdf_builder.md
# cdf_builder

Scans the 256-bin luminance histogram of a completed 640x480 frame, forms the cumulative distribution function, writes it to the CDF bank used by the output mapper, and finds the minimum non-zero CDF value. Sits between the histogram accumulation stage and the frame controller. Its `cdf_min`/`cdf_valid` pair feeds the controller's `Cdf_Min`/`cdf_valid` inputs, and `cdf_bank` follows the controller's ping-pong input bank. Each histogram bin is zeroed as it is consumed, so the bank is ready for the next frame.

## Interface
- `BINS`, 256, number of histogram bins.
- `ADDR_W`, 8, bin address width.
- `COUNT_W`, 20, width of histogram counts and CDF values.
- `PIXELS`, 307200, expected pixel total per frame.
- `clock`  in  1  sole clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a scan. Honoured only in IDLE.
- `bank`  in  1  histogram/CDF bank select. Sampled when `start` is accepted.
- `hist_rd_en`  out  1  histogram read strobe.
- `hist_rd_addr`  out  ADDR_W  histogram read address.
- `hist_rd_data`  in  COUNT_W  histogram data. Returned exactly 1 cycle after `hist_rd_en`.
- `hist_clr_en`  out  1  write zero to `hist_clr_addr`.
- `hist_clr_addr`  out  ADDR_W  bin being cleared.
- `cdf_wr_en`  out  1  CDF RAM write strobe.
- `cdf_wr_addr`  out  ADDR_W  CDF write address.
- `cdf_wr_data`  out  COUNT_W  cumulative count written.
- `cdf_bank`  out  1  bank latched at start. Applies to all read, clear and write ports.
- `cdf_min`  out  COUNT_W  first non-zero CDF value. Held from `cdf_valid` until the next accepted start.
- `cdf_valid`  out  1  one-cycle pulse; scan complete, `cdf_min` valid.
- `busy`  out  1  scan in progress.
- `total_error`  out  1  final sum differs from PIXELS, or the accumulator saturated. Valid with `cdf_valid`; held until the next start.
- `flat_image`  out  1  `cdf_min == PIXELS`, meaning the downstream divisor would be zero. Same validity as `total_error`.

## Operation
- FSM states:
  - IDLE -> READ on `start`.
  - READ: issues addresses 0..255, one per cycle. -> DRAIN after address 255.
  - DRAIN: waits 2 cycles for the last data and write. -> DONE.
  - DONE: pulses `cdf_valid`. -> IDLE.
- Accumulator `acc` (COUNT_W) clears on start. For each returned bin k: `acc_next = acc + hist_rd_data`, computed with a COUNT_W+1 bit sum.
- Saturation: if the carry is set, `acc_next = 2^COUNT_W-1` and a sticky `sat` flag is set.
- CDF write: registered `cdf_wr_en=1`, `cdf_wr_addr=k`, `cdf_wr_data=acc_next`.
- Histogram clear: `hist_clr_en`/`hist_clr_addr=k` asserted in the same cycle as the write for bin k.
- Min capture: the first `acc_next != 0` in scan order is captured into the min register. If no non-zero value occurs, the min is 0.
- At DONE:
  - `cdf_min` <= captured min.
  - `total_error` <= `sat | (acc != PIXELS)`.
  - `flat_image` <= `(min == PIXELS)`.
- `start` while not IDLE is ignored; no queueing. `bank` changes after acceptance have no effect.
- Reset, at any time including mid-scan, forces IDLE. All strobes drop at that edge, no `cdf_valid` is produced, and the accumulator, min and flags are zeroed.
- Reset value of every output: 0.

## Timing
- `start` sampled high in IDLE at edge t:
  - `busy`=1 from t+1 through t+259.
  - `hist_rd_en`=1 for t+1..t+256, with `hist_rd_addr` = cycle - (t+1).
- Bin k: data arrives at t+2+k; `cdf_wr_en`/`hist_clr_en` for bin k are at t+3+k (last at t+258).
- `cdf_valid` is high at t+259 only, with `cdf_min`/`total_error`/`flat_image` already updated. `busy`=0 at t+260.
- Scan latency: 259 cycles from start to `cdf_valid`.
- A new `start` is accepted no earlier than t+260. Back-to-back frames run with a 260-cycle period.
- A clear and a read never target the same address in the same cycle; the clear of bin k is 2 cycles after its read.

## Test plan
- Uniform histogram, every bin 1200, start at t:
  - `cdf_wr_data[k]` = 1200*(k+1); the last write is 307200 at t+258.
  - `cdf_valid` at t+259, `cdf_min`=1200, `total_error`=0, `flat_image`=0.
  - All 256 bins read back 0 afterwards.
- Flat image, bin 100 = 307200 and all others 0:
  - CDF is 0 for k<100 and 307200 for k>=100.
  - `cdf_min`=307200, `flat_image`=1, `total_error`=0.
- Leading zeros: bins 0..9 = 0, bin 10 = 5, bin 255 = 307195, others 0 -> `cdf_min`=5, `total_error`=0.
- Bad total and saturation:
  - Every bin = 1 -> final sum 256, `total_error`=1, `cdf_min`=1.
  - Every bin = 0xFFFFF -> `cdf_wr_data` sticks at 0xFFFFF from bin 0 onward, `total_error`=1.
- Bank and busy handling:
  - Start with `bank`=1, toggle `bank` and pulse `start` at t+50 -> `cdf_bank` stays 1, only one `cdf_valid` (at t+259).
  - A start at t+260 is accepted.
- Reset mid-scan: assert `reset` at t+100.
  - At t+101: `busy`/`hist_rd_en`/`cdf_wr_en` are 0 and `cdf_min`=0; no `cdf_valid` follows.
  - A subsequent uniform-frame start completes normally with `cdf_min`=1200.
